// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ready timeout and precise exception entry.
// Optional macro CONTROL_FSM_IRQ_EN adds the irq input and interrupt entry at instruction boundaries.
module control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rt_field,
  input  logic       mem_ready,
`ifdef CONTROL_FSM_IRQ_EN
  input  logic       irq,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic [1:0] reg_dst,
  output logic       load_signed,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       rfe,
  output logic       epc_we,
  output logic       exc_valid,
  output logic [2:0] exc_code
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_EXC
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_rfe;
    logic       reg_write;
    logic [1:0] mem_size;
    logic       load_signed;
  } ctrl_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  ctrl_t            dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       exc_code_q, exc_code_d;
  logic             dec_undef, dec_trap;
  logic             irq_take;
  logic             expired;

`ifdef CONTROL_FSM_IRQ_EN
  assign irq_take = irq && (cnt_q == '0);
`else
  assign irq_take = 1'b0;
`endif

  assign expired = (cnt_q == TMO) && !mem_ready;

  // Instruction classification; only sampled into ctrl_q while in DECODE.
  always_comb begin
    dec        = '0;
    dec.alu_op = 4'd1;
    dec_undef  = 1'b0;
    dec_trap   = 1'b0;
    case (op)
      6'b000000: begin
        case (func)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011: begin
            dec.reg_dst   = 2'b01;
            dec.reg_write = 1'b1;
          end
          6'b001000: dec.is_branch = 1'b1;
          6'b001001: begin
            dec.is_branch = 1'b1;
            dec.reg_dst   = 2'b10;
            dec.reg_write = 1'b1;
          end
          default: dec_undef = 1'b1;
        endcase
      end
      6'b000001: begin
        if (rt_field inside {5'b00000, 5'b00001, 5'b10000, 5'b10001}) begin
          dec.is_branch = 1'b1;
          if (rt_field[4]) begin
            dec.reg_dst   = 2'b10;
            dec.reg_write = 1'b1;
          end
        end else begin
          dec_undef = 1'b1;
        end
      end
      6'b000010, 6'b000100, 6'b000101, 6'b000110, 6'b000111: dec.is_branch = 1'b1;
      6'b000011: begin
        dec.is_branch = 1'b1;
        dec.reg_dst   = 2'b10;
        dec.reg_write = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.alu_op    = {1'b0, op[2:0]} + 4'd1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      6'b010000: begin
        if (func == 6'b010000) dec.is_rfe = 1'b1;
        else                   dec_undef  = 1'b1;
      end
      6'b010001: dec_trap = 1'b1;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: begin
        dec.alu_src     = 1'b1;
        dec.is_load     = !op[3];
        dec.is_store    = op[3];
        // lb/lh sign-extend; lw, lbu, lhu do not.
        dec.load_signed = !op[3] && !op[2] && !op[1];
        case (op[1:0])
          2'b00:   dec.mem_size = 2'b10;
          2'b01:   dec.mem_size = 2'b01;
          default: dec.mem_size = 2'b00;
        endcase
      end
      default: dec_undef = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      exc_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      exc_code_q <= exc_code_d;
    end
  end

  // cnt_d defaults to zero so every entry into FETCH or MEM starts a fresh wait count.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    cnt_d       = '0;
    exc_code_d  = exc_code_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 2'b00;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    alu_op      = 4'd0;
    alu_src     = 1'b0;
    reg_dst     = 2'b00;
    load_signed = 1'b0;
    mem_to_reg  = 1'b0;
    reg_we      = 1'b0;
    rfe         = 1'b0;
    epc_we      = 1'b0;
    exc_valid   = 1'b0;
    exc_code    = 3'd0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (irq_take) begin
          state_d    = S_EXC;
          exc_code_d = 3'd5;
        end else if (mem_ready) begin
          mem_req = 1'b1;
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d    = S_EXC;
          exc_code_d = 3'd3;
        end else begin
          mem_req = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ctrl_d = dec;
        if (dec_undef) begin
          state_d    = S_EXC;
          exc_code_d = 3'd1;
        end else if (dec_trap) begin
          state_d    = S_EXC;
          exc_code_d = 3'd2;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = ctrl_q.alu_op;
        alu_src = ctrl_q.alu_src;
        reg_dst = ctrl_q.reg_dst;
        if (ctrl_q.is_branch) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
        if (ctrl_q.is_rfe) begin
          rfe    = 1'b1;
          pc_we  = 1'b1;
          pc_src = 2'd3;
        end
        if (ctrl_q.is_load || ctrl_q.is_store) state_d = S_MEM;
        else if (ctrl_q.reg_write)             state_d = S_WB;
        else                                   state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_req  = 1'b1;
          mem_we   = ctrl_q.is_store;
          mem_size = ctrl_q.mem_size;
          state_d  = ctrl_q.is_store ? S_FETCH : S_WB;
        end else if (expired) begin
          state_d    = S_EXC;
          exc_code_d = 3'd4;
        end else begin
          mem_req  = 1'b1;
          mem_we   = ctrl_q.is_store;
          mem_size = ctrl_q.mem_size;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_we      = 1'b1;
        mem_to_reg  = ctrl_q.is_load;
        load_signed = ctrl_q.load_signed;
        state_d     = S_FETCH;
      end
      S_EXC: begin
        exc_valid = 1'b1;
        exc_code  = exc_code_q;
        epc_we    = 1'b1;
        pc_we     = 1'b1;
        pc_src    = 2'd2;
        state_d   = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: a per-instruction cycle model predicts every output vector.
module tb_control_fsm;

  localparam int TMO = 4;
`ifdef CONTROL_FSM_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       load_signed;
    logic       mem_to_reg;
    logic       reg_we;
    logic       rfe;
    logic       epc_we;
    logic       exc_valid;
    logic [2:0] exc_code;
  } outs_t;

  typedef enum logic [3:0] {K_UNDEF, K_TRAP, K_ALU, K_BR, K_LINK, K_LOAD, K_STORE, K_RFE} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] size;
    logic       sgn;
  } info_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rt;
    int         fw;
    int         mw;
    bit         irqf;
    bit         irq_mid;
  } plan_t;

  typedef struct {
    logic  rdy;
    logic  irq;
    outs_t o;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_r = 6'd0;
  logic [5:0] func_r = 6'd0;
  logic [4:0] rt_r = 5'd0;
  logic       mem_ready = 1'b0;
  logic       irq_r = 1'b0;

  logic       mem_req, mem_we, ir_we, pc_we, alu_src, load_signed, mem_to_reg;
  logic       reg_we, rfe, epc_we, exc_valid;
  logic [1:0] mem_size, pc_src, reg_dst;
  logic [3:0] alu_op;
  logic [2:0] exc_code;
  outs_t      act;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  outs_t exp_q[$];
  cyc_t  seq[$];

  logic [5:0] op_list [24] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                               6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd32, 6'd33,
                               6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};
  logic [5:0] func_list [18] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9, 6'd32,
                                 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};
  logic [4:0] rt_list [4] = '{5'd0, 5'd1, 5'd16, 5'd17};

  control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op_r), .func(func_r), .rt_field(rt_r),
    .mem_ready(mem_ready),
`ifdef CONTROL_FSM_IRQ_EN
    .irq(irq_r),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dst(reg_dst), .load_signed(load_signed), .mem_to_reg(mem_to_reg),
    .reg_we(reg_we), .rfe(rfe), .epc_we(epc_we), .exc_valid(exc_valid),
    .exc_code(exc_code)
  );

  assign act = {mem_req, mem_we, mem_size, ir_we, pc_we, pc_src, alu_op, alu_src,
                reg_dst, load_signed, mem_to_reg, reg_we, rfe, epc_we, exc_valid, exc_code};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      outs_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cyc%0d outputs: got %h want %h (mem_ready=%b irq=%b op=%h func=%h)",
                 cyc, act, e, mem_ready, irq_r, op_r, func_r);
      end
    end
  end

  function automatic info_t classify(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    info_t i;
    i = '0;
    i.kind = K_UNDEF;
    i.alu_op = 4'd1;
    if (o == 6'd0) begin
      if (f inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, [6'd32:6'd39], 6'd42, 6'd43}) begin
        i.kind = K_ALU;
        i.reg_dst = 2'd1;
      end else if (f == 6'd8) i.kind = K_BR;
      else if (f == 6'd9) i.kind = K_LINK;
    end else if (o == 6'd1) begin
      if (r inside {5'd0, 5'd1, 5'd16, 5'd17}) i.kind = (r >= 5'd16) ? K_LINK : K_BR;
    end else if (o inside {6'd2, [6'd4:6'd7]}) i.kind = K_BR;
    else if (o == 6'd3) i.kind = K_LINK;
    else if (o inside {[6'd8:6'd15]}) begin
      i.kind = K_ALU;
      i.alu_src = 1'b1;
      i.alu_op = 4'(o - 6'd7);
    end else if (o == 6'd16) begin
      if (f == 6'd16) i.kind = K_RFE;
    end else if (o == 6'd17) i.kind = K_TRAP;
    else if (o inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37}) begin
      i.kind = K_LOAD;
      i.alu_src = 1'b1;
      i.sgn = (o == 6'd32) || (o == 6'd33);
    end else if (o inside {6'd40, 6'd41, 6'd43}) begin
      i.kind = K_STORE;
      i.alu_src = 1'b1;
    end
    if (i.kind == K_LINK) i.reg_dst = 2'd2;
    if (i.kind == K_LOAD || i.kind == K_STORE)
      i.size = (o % 4 == 0) ? 2'b10 : (o % 4 == 1) ? 2'b01 : 2'b00;
    return i;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic nirq(input plan_t p);
    return p.irq_mid ? 1'b1 : ($urandom_range(0, 7) == 0);
  endfunction

  task automatic push(input logic r, input logic iq, input outs_t o);
    cyc_t c;
    c.rdy = r;
    c.irq = iq;
    c.o = o;
    seq.push_back(c);
  endtask

  task automatic push_exc(input logic [2:0] code, input logic iq);
    outs_t o;
    o = '0;
    o.exc_valid = 1'b1;
    o.exc_code = code;
    o.epc_we = 1'b1;
    o.pc_we = 1'b1;
    o.pc_src = 2'd2;
    push(rb(), iq, o);
  endtask

  // Expected cycle list for one instruction, starting at its first FETCH cycle.
  task automatic build(input plan_t p);
    outs_t o;
    info_t inf;
    seq.delete();
    if (IRQ_ON && p.irqf) begin
      push(rb(), 1'b1, '0);
      push_exc(3'd5, nirq(p));
      return;
    end
    for (int k = 0; k <= p.fw; k++) begin
      o = '0;
      if (k < p.fw && k == TMO) begin
        push(1'b0, nirq(p), o);
        push_exc(3'd3, nirq(p));
        return;
      end
      o.mem_req = 1'b1;
      if (k == p.fw) begin
        o.ir_we = 1'b1;
        o.pc_we = 1'b1;
      end
      push(k == p.fw, (k == 0) ? p.irqf : nirq(p), o);
    end
    push(rb(), nirq(p), '0);
    inf = classify(p.op, p.func, p.rt);
    if (inf.kind == K_UNDEF) begin push_exc(3'd1, nirq(p)); return; end
    if (inf.kind == K_TRAP)  begin push_exc(3'd2, nirq(p)); return; end
    o = '0;
    o.alu_op = inf.alu_op;
    o.alu_src = inf.alu_src;
    o.reg_dst = inf.reg_dst;
    if (inf.kind == K_BR || inf.kind == K_LINK) begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
    if (inf.kind == K_RFE) begin o.rfe = 1'b1; o.pc_we = 1'b1; o.pc_src = 2'd3; end
    push(rb(), nirq(p), o);
    if (inf.kind == K_LOAD || inf.kind == K_STORE) begin
      for (int k = 0; k <= p.mw; k++) begin
        o = '0;
        if (k < p.mw && k == TMO) begin
          push(1'b0, nirq(p), o);
          push_exc(3'd4, nirq(p));
          return;
        end
        o.mem_req = 1'b1;
        o.mem_we = (inf.kind == K_STORE);
        o.mem_size = inf.size;
        push(k == p.mw, nirq(p), o);
      end
      if (inf.kind == K_STORE) return;
    end
    if (inf.kind == K_ALU || inf.kind == K_LINK || inf.kind == K_LOAD) begin
      o = '0;
      o.reg_we = 1'b1;
      o.mem_to_reg = (inf.kind == K_LOAD);
      o.load_signed = (inf.kind == K_LOAD) && inf.sgn;
      push(rb(), nirq(p), o);
    end
  endtask

  function automatic plan_t mk(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                               input int fw, input int mw, input bit irqf, input bit irq_mid);
    plan_t p;
    p.op = o; p.func = f; p.rt = r; p.fw = fw; p.mw = mw;
    p.irqf = irqf; p.irq_mid = irq_mid;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.op = 6'($urandom);
    p.func = 6'($urandom);
    p.rt = 5'($urandom);
    case ($urandom_range(0, 3))
      1: p.op = op_list[$urandom_range(0, 23)];
      2: begin p.op = 6'd0; p.func = func_list[$urandom_range(0, 17)]; end
      3: begin p.op = 6'd1; p.rt = rt_list[$urandom_range(0, 3)]; end
      default: ;
    endcase
    if (p.op == 6'd16 && $urandom_range(0, 1) == 1) p.func = 6'd16;
    p.fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2)) : 0;
    p.mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2)) : 0;
    p.irqf = IRQ_ON && ($urandom_range(0, 7) == 0);
    p.irq_mid = 1'b0;
    return p;
  endfunction

  task automatic step(input logic r, input logic iq, input outs_t e);
    @(posedge clk);
    #1;
    mem_ready = r;
    irq_r = iq;
    exp_q.push_back(e);
  endtask

  task automatic play(input plan_t p);
    build(p);
    for (int i = 0; i < seq.size(); i++) begin
      step(seq[i].rdy, seq[i].irq, seq[i].o);
      if (i == 0) begin op_r = p.op; func_r = p.func; rt_r = p.rt; end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic reset_cycles();
    @(posedge clk); #1; rst_n = 1'b0; mem_ready = 1'b0; irq_r = 1'b0; exp_q.push_back('0);
    @(posedge clk); #1; exp_q.push_back('0);
    @(posedge clk); #1; rst_n = 1'b1; exp_q.push_back('0);
  endtask

  initial begin
    outs_t o;
    rst_n = 1'b0;

    // Pin the model against hand-derived cycle counts and fields.
    build(mk(6'd8, 6'd0, 5'd0, 0, 0, 0, 0));
    chk("pin_addi_len", seq.size(), 4);
    chk("pin_addi_aluop", int'(seq[2].o.alu_op), 1);
    build(mk(6'd33, 6'd0, 5'd0, 0, 3, 0, 0));
    chk("pin_lh_len", seq.size(), 8);
    chk("pin_lh_size", int'(seq[4].o.mem_size), 1);
    chk("pin_lh_wb", int'({seq[7].o.reg_we, seq[7].o.mem_to_reg, seq[7].o.load_signed}), 7);
    build(mk(6'd0, 6'h3f, 5'd0, 0, 0, 0, 0));
    chk("pin_undef_len", seq.size(), 3);
    chk("pin_undef_code", int'(seq[2].o.exc_code), 1);
    build(mk(6'd8, 6'd0, 5'd0, TMO + 1, 0, 0, 0));
    chk("pin_fto_len", seq.size(), TMO + 2);
    chk("pin_fto_code", int'(seq[TMO + 1].o.exc_code), 3);
    build(mk(6'd43, 6'd0, 5'd0, 0, 0, 0, 0));
    chk("pin_sw_len", seq.size(), 4);

    // Reset held, then BOOT with all outputs low.
    repeat (2) begin @(posedge clk); #1; exp_q.push_back('0); end
    @(posedge clk); #1; rst_n = 1'b1; exp_q.push_back('0);

    // Literal addi with zero-wait memory.
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    step(1'b1, 1'b0, o);
    op_r = 6'b001000; func_r = 6'd0; rt_r = 5'd0;
    step(1'b1, 1'b0, '0);
    o = '0; o.alu_op = 4'b0001; o.alu_src = 1'b1;
    step(1'b1, 1'b0, o);
    o = '0; o.reg_we = 1'b1;
    step(1'b1, 1'b0, o);

    play(mk(6'd33, 6'd0, 5'd0, 0, 3, 0, 0));         // lh, 3 wait cycles
    play(mk(6'd0, 6'h3f, 5'd0, 0, 0, 0, 0));         // undefined R function
    play(mk(6'd8, 6'd0, 5'd0, TMO + 1, 0, 0, 0));    // fetch timeout
    play(mk(6'd8, 6'd0, 5'd0, TMO, 0, 0, 0));        // ready on the expiry cycle
    play(mk(6'd43, 6'd0, 5'd0, 0, 0, 0, 0));         // sw
    play(mk(6'd35, 6'd0, 5'd0, 0, TMO + 2, 0, 0));   // data timeout
    play(mk(6'd16, 6'd16, 5'd0, 0, 0, 0, 0));        // rfe
    play(mk(6'd3, 6'd0, 5'd0, 0, 0, 0, 0));          // jal
    play(mk(6'd0, 6'd9, 5'd0, 1, 0, 0, 0));          // jalr
    play(mk(6'd0, 6'd8, 5'd0, 0, 0, 0, 0));          // jr
    play(mk(6'd1, 6'd0, 5'd17, 0, 0, 0, 0));         // bgezal
    play(mk(6'd1, 6'd0, 5'd2, 0, 0, 0, 0));          // bad regimm rt
    play(mk(6'd17, 6'd0, 5'd0, 0, 0, 0, 0));         // trap
    play(mk(6'd36, 6'd0, 5'd0, 2, 1, 0, 0));         // lbu
    if (IRQ_ON) begin
      play(mk(6'd8, 6'd0, 5'd0, 0, 0, 1, 0));        // irq at FETCH entry
      play(mk(6'd35, 6'd0, 5'd0, 2, 2, 0, 1));       // irq held through the instruction
      play(mk(6'd8, 6'd0, 5'd0, 0, 0, 1, 0));        // taken at the next boundary
    end
    play(mk(6'd13, 6'd0, 5'd0, 0, 0, 0, 0));

    // Reset in the middle of an outstanding fetch.
    build(mk(6'd35, 6'd0, 5'd0, TMO + 3, 0, 0, 0));
    step(seq[0].rdy, 1'b0, seq[0].o);
    step(seq[1].rdy, seq[1].irq, seq[1].o);
    reset_cycles();

    for (int n = 0; n < 400; n++) play(rand_plan());

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control sequencer for the 32-bit MIPS-subset core. It replaces single-cycle decode with a registered state machine: FETCH → DECODE → EXEC → MEM → WB. It adds a memory ready handshake with a programmable timeout and precise exception entry (undefined instruction, trap, bus timeout). The block sits between the instruction register / datapath and the unified memory port, and owns all datapath write enables.

## Interface
- `MEM_TIMEOUT`, default 16: cycles to wait for `mem_ready` before a bus-timeout exception; legal range 1..255.
- `CNT_W`, default 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `op` in 6: IR[31:26], stable from DECODE until the next FETCH.
- `func` in 6: IR[5:0].
- `rt_field` in 5: IR[20:16].
- `mem_ready` in 1: memory completes the current request this cycle.
- `irq` in 1: level interrupt request; present only with `CONTROL_FSM_IRQ_EN`.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: store request.
- `mem_size` out 2: 00 word, 01 half, 10 byte.
- `ir_we` out 1: load IR from the memory read data.
- `pc_we` out 1: PC update.
- `pc_src` out 2: 0 = PC+4, 1 = branch/jump target (datapath evaluates condition), 2 = exception vector, 3 = EPC.
- `alu_op` out 4, `alu_src` out 1, `reg_dst` out 2, `load_signed` out 1, `mem_to_reg` out 1: datapath controls.
- `reg_we` out 1: register-file write, active-high.
- `rfe` out 1: restore status from exception frame.
- `epc_we` out 1: capture EPC.
- `exc_valid` out 1, `exc_code` out 3: exception entry strobe and cause.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, EXC. Encoding is free.
- **BOOT:** entered on reset. All outputs are 0. Advances to FETCH unconditionally.
- **FETCH:**
  - Drives `mem_req`=1, `mem_we`=0, `mem_size`=00.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=0, → DECODE.
- **DECODE:** classifies `op`/`func`/`rt_field` and latches the control word into `ctrl_q`.
  - Undefined encoding → EXC with code 1.
  - `op`=010001 (trap) → EXC with code 2.
  - Otherwise → EXEC.
  - Defined R functions: sll, srl, sra, sllv, srlv, srav, jr, jalr, add, addu, sub, subu, and, or, xor, nor, slt, sltu.
  - `op`=000001 accepts `rt_field` ∈ {00000, 00001, 10000, 10001} only.
- **EXEC:** drives `alu_op`/`alu_src`/`reg_dst` from `ctrl_q`.
  - ALU op codes: 1 = add/default, 2 addiu, 3 slti, 4 sltiu, 5 andi, 6 ori, 7 xori, 8 lui.
  - Branch/jump: `pc_we`=1, `pc_src`=1.
  - Link forms (jal, jalr, bgezal, bltzal): `reg_dst`=10; link instructions go to WB.
  - rfe: `rfe`=1, `pc_we`=1, `pc_src`=3.
  - Next state: load/store → MEM; register writers → WB; else → FETCH.
- **MEM:**
  - Drives `mem_req`=1, `mem_we`=store, and `mem_size` from `ctrl_q`.
  - On `mem_ready`: load → WB, store → FETCH.
- **WB:** `reg_we`=1; `mem_to_reg` and `load_signed` come from `ctrl_q` (lb/lh signed, lbu/lhu unsigned). → FETCH.
- **EXC:** one cycle.
  - `exc_valid`=1, `exc_code` = latched cause, `epc_we`=1, `pc_we`=1, `pc_src`=2. → FETCH.
  - Cause codes: 1 undefined, 2 trap, 3 fetch timeout, 4 data timeout, 5 interrupt.
- **Wait counter:**
  - Clears on entry to FETCH and MEM; increments each cycle `mem_ready`=0 in those states.
  - Counter == MEM_TIMEOUT with `mem_ready`=0 → EXC with code 3 (FETCH) or 4 (MEM); `mem_req` drops that cycle.
  - `mem_ready`=1 in the same cycle as expiry: completion wins.

## Timing
- Reset: state BOOT, `ctrl_q`=0, counter 0, `exc_code`=0; every output 0 while `rst_n`=0 and in BOOT.
- Reset mid-operation aborts immediately; an outstanding memory request is dropped without handshake.
- Minimum cycles with zero-wait memory, counting FETCH, DECODE and EXEC:
  - ALU instruction: 4.
  - Branch/store/rfe: 3 or 4 (store adds MEM).
  - Load: 5.
  - Exception: FETCH + DECODE + EXC = 3.
- Each memory wait cycle adds 1.
- All outputs are a combinational function of registered state, `ctrl_q` and `mem_ready`. `ir_we`/`pc_we` in FETCH are qualified by `mem_ready` in the same cycle.
- `exc_valid`, `epc_we` and `rfe` are single-cycle pulses.

## Configuration
- `CONTROL_FSM_IRQ_EN` defined:
  - `irq` port exists. `irq`=1 in the first cycle of FETCH (counter 0) → EXC with code 5; no fetch is issued.
  - Interrupts are never taken mid-instruction.
- Not defined: no `irq` port, code 5 is never produced, and FETCH always issues.

## Test plan
- Reset release, `mem_ready` tied 1, `op`=001000 → BOOT, FETCH, DECODE, EXEC (`alu_op`=0001, `alu_src`=1), WB `reg_we`=1; back in FETCH at cycle 5.
- lh with `mem_ready` delayed 3 cycles in MEM → `mem_size`=01 held, WB with `load_signed`=1, `mem_to_reg`=1.
- `op`=000000, `func`=111111 → EXC one cycle later, `exc_code`=1, `pc_src`=2, `epc_we`=1.
- `mem_ready` held 0 in FETCH, MEM_TIMEOUT=4 → EXC after exactly 4 wait cycles, `exc_code`=3; repeated with `mem_ready`=1 on cycle 4 → normal DECODE.
- sw, `mem_ready`=1 → MEM with `mem_we`=1, then FETCH; `reg_we` never asserted.
- With `CONTROL_FSM_IRQ_EN`: `irq`=1 at FETCH entry → EXC code 5, `mem_req` never asserted that instruction; `irq` raised during MEM → taken at the next FETCH.
